// File: rtl/card_lock_pkg.sv
// Shared types for the card lock: card kinds, controller states and a
// saturating counter helper.
package card_lock_pkg;

  typedef enum logic [1:0] {
    GUEST     = 2'b00,
    NEW_GUEST = 2'b01,
    MANAGER   = 2'b10,
    EMERGENCY = 2'b11
  } card_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EVAL,
    ST_TRIP,
    ST_LOCKOUT,
    ST_WAIT_REMOVE
  } state_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v, input logic [3:0] lim);
    return (v >= lim) ? lim : v + 4'd1;
  endfunction

endpackage

// File: rtl/card_code_store.sv
// Guest code memory: NUM_CODES registered slots with valid bits, parallel
// match, round-robin overwrite of the oldest slot and a clear-all.
module card_code_store
  import card_lock_pkg::*;
#(
  parameter int CODE_W    = 16,
  parameter int NUM_CODES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_i,
  input  logic              wr_en_i,
  input  logic              clr_all_i,
  output logic              match_o
);

  localparam int PTR_W = $clog2(NUM_CODES);

  logic [CODE_W-1:0]    code_q [NUM_CODES];
  logic [NUM_CODES-1:0] valid_q;
  logic [NUM_CODES-1:0] hit;
  logic [PTR_W-1:0]     ptr_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CODES; gi++) begin : g_match
      assign hit[gi] = valid_q[gi] && (code_q[gi] == code_i);
    end
  endgenerate

  assign match_o = |hit;

  // A code already present is never stored twice, so the pointer only moves on a real write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      ptr_q   <= '0;
      for (int i = 0; i < NUM_CODES; i++) code_q[i] <= '0;
    end else if (clr_all_i) begin
      valid_q <= '0;
      ptr_q   <= '0;
    end else if (wr_en_i && !match_o) begin
      code_q[ptr_q]  <= code_i;
      valid_q[ptr_q] <= 1'b1;
      ptr_q          <= ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/card_lock_gen2.sv
// Hotel door card lock controller: evaluates inserted cards, pulses the door
// trip, and locks out guests after repeated failures.
module card_lock_gen2
  import card_lock_pkg::*;
#(
  parameter int CODE_W         = 16,
  parameter int NUM_CODES      = 4,
  parameter int TRIP_CYCLES    = 8,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              card_present,
  input  logic [CODE_W-1:0] entry_code_on_card,
  input  logic [1:0]        card_type,
  output logic              card_read,
  output logic              trip_lock_for_guest,
  output logic              reject,
  output logic              locked_out,
  output logic              guest_disabled,
  output logic [3:0]        fail_count
);

  localparam int TRIP_W = $clog2(TRIP_CYCLES + 1);
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES + 1);

  state_e            state_q, state_d;
  logic              card_present_q;
  logic [CODE_W-1:0] code_q, code_d;
  card_type_e        type_q, type_d;
  logic [TRIP_W-1:0] trip_cnt_q, trip_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [3:0]        fail_q, fail_d;
  logic              gd_q, gd_d;
  logic              reject_q, reject_d;
  logic              store_wr, store_clr, store_match;
  logic              insertion;

  assign insertion = card_present && !card_present_q;

  card_code_store #(
    .CODE_W   (CODE_W),
    .NUM_CODES(NUM_CODES)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .code_i   (code_q),
    .wr_en_i  (store_wr),
    .clr_all_i(store_clr),
    .match_o  (store_match)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      card_present_q <= 1'b0;
      code_q         <= '0;
      type_q         <= GUEST;
      trip_cnt_q     <= '0;
      lock_cnt_q     <= '0;
      fail_q         <= '0;
      gd_q           <= 1'b0;
      reject_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      card_present_q <= card_present;
      code_q         <= code_d;
      type_q         <= type_d;
      trip_cnt_q     <= trip_cnt_d;
      lock_cnt_q     <= lock_cnt_d;
      fail_q         <= fail_d;
      gd_q           <= gd_d;
      reject_q       <= reject_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    type_d     = type_q;
    trip_cnt_d = trip_cnt_q;
    lock_cnt_d = lock_cnt_q;
    fail_d     = fail_q;
    gd_d       = gd_q;
    reject_d   = 1'b0;
    store_wr   = 1'b0;
    store_clr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (insertion) begin
          code_d  = entry_code_on_card;
          type_d  = card_type_e'(card_type);
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        trip_cnt_d = '0;
        case (type_q)
          GUEST: begin
            if (gd_q) begin
              reject_d = 1'b1;
              state_d  = ST_WAIT_REMOVE;
            end else if (store_match) begin
              fail_d  = '0;
              state_d = ST_TRIP;
            end else begin
              reject_d = 1'b1;
              fail_d   = sat_inc4(fail_q, 4'(MAX_FAILS));
              if (fail_d == 4'(MAX_FAILS)) begin
                lock_cnt_d = '0;
                state_d    = ST_LOCKOUT;
              end else begin
                state_d = ST_WAIT_REMOVE;
              end
            end
          end
          NEW_GUEST: begin
            if (gd_q) begin
              reject_d = 1'b1;
              state_d  = ST_WAIT_REMOVE;
            end else begin
              store_wr = 1'b1;
              fail_d   = '0;
              state_d  = ST_TRIP;
            end
          end
          MANAGER: begin
            fail_d  = '0;
            gd_d    = 1'b0;
            state_d = ST_TRIP;
          end
          default: begin
            gd_d      = 1'b1;
            store_clr = 1'b1;
            state_d   = ST_WAIT_REMOVE;
          end
        endcase
      end
      ST_TRIP: begin
        if (trip_cnt_q == TRIP_W'(TRIP_CYCLES - 1)) begin
          state_d = card_present ? ST_WAIT_REMOVE : ST_IDLE;
        end else begin
          trip_cnt_d = trip_cnt_q + 1'b1;
        end
      end
      ST_LOCKOUT: begin
        // Only a manager card can cut the lockout short; everything else is ignored.
        if (insertion && card_type_e'(card_type) == MANAGER) begin
          code_d  = entry_code_on_card;
          type_d  = MANAGER;
          state_d = ST_EVAL;
        end else if (lock_cnt_q == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
          fail_d  = '0;
          state_d = card_present ? ST_WAIT_REMOVE : ST_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      ST_WAIT_REMOVE: begin
        if (!card_present) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign card_read           = (state_q == ST_EVAL);
  assign trip_lock_for_guest = (state_q == ST_TRIP);
  assign locked_out          = (state_q == ST_LOCKOUT);
  assign reject              = reject_q;
  assign guest_disabled      = gd_q;
  assign fail_count          = fail_q;

endmodule

// File: tb/tb_card_lock_gen2.sv
// Scoreboard bench for card_lock_gen2: card stimulus queues expected decisions,
// trip lengths and lockout lengths; a monitor compares when the DUT shows them.
module tb_card_lock_gen2;
  import card_lock_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        card_present = 1'b0;
  logic [15:0] code = 16'h0;
  logic [1:0]  ctype = 2'b00;
  logic        card_read, trip, reject, locked_out, guest_disabled;
  logic [3:0]  fail_count;

  card_lock_gen2 dut (
    .clk                (clk),
    .reset              (reset),
    .card_present       (card_present),
    .entry_code_on_card (code),
    .card_type          (ctype),
    .card_read          (card_read),
    .trip_lock_for_guest(trip),
    .reject             (reject),
    .locked_out         (locked_out),
    .guest_disabled     (guest_disabled),
    .fail_count         (fail_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       trip;
    logic       rej;
    logic [3:0] fc;
    logic       lo;
    logic       gd;
  } dec_t;

  typedef struct {
    int         len;
    logic [3:0] fc_after;
  } lock_t;

  dec_t  dec_q[$];
  int    trip_q[$];
  lock_t lock_q[$];
  int    n_checks = 0;
  int    n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_dec(input logic t, input logic r, input logic [3:0] fc,
                            input logic lo, input logic gd);
    dec_t d;
    d.trip = t; d.rej = r; d.fc = fc; d.lo = lo; d.gd = gd;
    dec_q.push_back(d);
  endtask

  task automatic expect_lock(input int len, input logic [3:0] fc_after);
    lock_t l;
    l.len = len; l.fc_after = fc_after;
    lock_q.push_back(l);
  endtask

  task automatic card(input logic [1:0] t, input logic [15:0] c, input int hold, input int gap);
    @(negedge clk);
    ctype = t;
    code = c;
    card_present = 1'b1;
    repeat (hold) @(negedge clk);
    card_present = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: decision one cycle after card_read, pulse lengths on falling edges.
  initial begin
    logic  prev_read;
    int    trip_len, lock_len;
    dec_t  d;
    lock_t l;
    prev_read = 1'b0;
    trip_len = 0;
    lock_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_read = 1'b0;
        trip_len = 0;
        lock_len = 0;
      end else begin
        if (prev_read) begin
          if (dec_q.size() == 0) begin
            check("unexpected_decision", 1, 0);
          end else begin
            d = dec_q.pop_front();
            $display("decision t=%0t: trip=%0d reject=%0d fail_count=%0d locked_out=%0d guest_disabled=%0d",
                     $time, trip, reject, fail_count, locked_out, guest_disabled);
            check("dec_trip", int'(trip), int'(d.trip));
            check("dec_reject", int'(reject), int'(d.rej));
            check("dec_fail_count", int'(fail_count), int'(d.fc));
            check("dec_locked_out", int'(locked_out), int'(d.lo));
            check("dec_guest_disabled", int'(guest_disabled), int'(d.gd));
          end
        end
        prev_read = card_read;
        if (trip) begin
          trip_len++;
        end else if (trip_len > 0) begin
          if (trip_q.size() == 0) begin
            check("unexpected_trip", trip_len, 0);
          end else begin
            $display("trip pulse t=%0t: %0d cycles", $time, trip_len);
            check("trip_len", trip_len, trip_q.pop_front());
          end
          trip_len = 0;
        end
        if (locked_out) begin
          lock_len++;
        end else if (lock_len > 0) begin
          if (lock_q.size() == 0) begin
            check("unexpected_lockout", lock_len, 0);
          end else begin
            l = lock_q.pop_front();
            $display("lockout end t=%0t: %0d cycles, fail_count=%0d", $time, lock_len, fail_count);
            if (l.len >= 0) check("lock_len", lock_len, l.len);
            check("lock_fail_after", int'(fail_count), int'(l.fc_after));
          end
          lock_len = 0;
        end
      end
    end
  end

  // Every reset assertion must clear the outputs without waiting for a clock.
  initial begin
    forever begin
      @(posedge reset);
      #1;
      $display("reset t=%0t: trip=%0d locked_out=%0d reject=%0d card_read=%0d fail_count=%0d guest_disabled=%0d",
               $time, trip, locked_out, reject, card_read, fail_count, guest_disabled);
      check("rst_trip", int'(trip), 0);
      check("rst_locked_out", int'(locked_out), 0);
      check("rst_reject", int'(reject), 0);
      check("rst_card_read", int'(card_read), 0);
      check("rst_fail_count", int'(fail_count), 0);
      check("rst_guest_disabled", int'(guest_disabled), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Enrol 1234 and use it.
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h1234, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(GUEST, 16'h1234, 3, 12);

    // Three failures: full lockout, counter cleared at the end.
    expect_dec(0, 1, 1, 0, 0); card(GUEST, 16'hBEEF, 3, 4);
    expect_dec(0, 1, 2, 0, 0); card(GUEST, 16'hBEEF, 3, 4);
    expect_dec(0, 1, 3, 1, 0); expect_lock(1024, 0); card(GUEST, 16'hBEEF, 3, 1040);

    // Lockout again; a guest is ignored, a manager ends it.
    expect_dec(0, 1, 1, 0, 0); card(GUEST, 16'hBEEF, 3, 4);
    expect_dec(0, 1, 2, 0, 0); card(GUEST, 16'hBEEF, 3, 4);
    expect_dec(0, 1, 3, 1, 0); expect_lock(-1, 3); card(GUEST, 16'hBEEF, 3, 20);
    card(GUEST, 16'h1234, 3, 5);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(MANAGER, 16'h0000, 3, 12);

    // Fill the ring past capacity: oldest entries get overwritten.
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h1111, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h2222, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h3333, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h4444, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h5555, 3, 12);
    expect_dec(0, 1, 1, 0, 0); card(GUEST, 16'h1111, 3, 4);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(GUEST, 16'h5555, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h5555, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(GUEST, 16'h2222, 3, 12);
    expect_dec(0, 1, 1, 0, 0); card(GUEST, 16'h1234, 3, 4);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(GUEST, 16'h4444, 3, 12);

    // Emergency disables guests and wipes the store; manager re-enables.
    expect_dec(0, 0, 0, 0, 1); card(EMERGENCY, 16'h0000, 3, 4);
    expect_dec(0, 1, 0, 0, 1); card(GUEST, 16'h1234, 3, 4);
    expect_dec(0, 1, 0, 0, 1); card(NEW_GUEST, 16'h1234, 3, 4);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(MANAGER, 16'h0000, 3, 12);
    expect_dec(0, 1, 1, 0, 0); card(GUEST, 16'h2222, 3, 4);
    expect_dec(0, 1, 2, 0, 0); card(GUEST, 16'h1234, 3, 4);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(NEW_GUEST, 16'h7777, 3, 12);
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8); card(GUEST, 16'h7777, 3, 12);

    // Reset mid-trip with the card held: exactly one re-evaluation after release.
    expect_dec(1, 0, 0, 0, 0);
    @(negedge clk);
    ctype = MANAGER;
    code = 16'h0000;
    card_present = 1'b1;
    repeat (4) @(posedge clk);
    #3 reset = 1'b1;
    expect_dec(1, 0, 0, 0, 0); trip_q.push_back(8);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (25) @(negedge clk);
    card_present = 1'b0;
    repeat (5) @(negedge clk);

    check("pending_decisions", dec_q.size(), 0);
    check("pending_trips", trip_q.size(), 0);
    check("pending_lockouts", lock_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
